// File: rtl/aes_stream_ctrl.sv
// Streaming front-end for a fixed-latency aes_128 core: credit-based input flow control,
// tag pipeline to capture ciphertexts, and a first-word-fall-through response FIFO.
module aes_stream_ctrl #(
  parameter int unsigned AESLatency = 21,
  parameter int unsigned FIFODepth  = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [255:0] CmdIn,
  input  logic         CmdInValid,
  output logic         CmdInReady,
  output logic [127:0] AESState,
  output logic [127:0] AESKey,
  input  logic [127:0] AESOut,
  output logic [127:0] RspOut,
  output logic         RspOutValid,
  input  logic         RspOutReady
);
  localparam int unsigned CW = $clog2(FIFODepth + 1);
  localparam int unsigned PW = $clog2(FIFODepth);
  localparam logic [CW-1:0] DEPTH = CW'(FIFODepth);

  logic              init_q;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AESLatency:0] tag_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [127:0]      mem_q [FIFODepth];
  logic              accept, xfer, fifo_wr;

  // init_q keeps CmdInReady low for the cycle right after the last reset edge
  assign CmdInReady  = init_q && Reset && (outst_q < DEPTH);
  assign RspOutValid = Reset && (cnt_q != '0);
  assign RspOut      = mem_q[rptr_q];

  assign accept  = CmdInValid && CmdInReady;
  assign xfer    = RspOutValid && RspOutReady;
  assign fifo_wr = tag_q[AESLatency];

  always_comb begin
    outst_d = outst_q;
    cnt_d   = cnt_q;
    case ({accept, xfer})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    case ({fifo_wr, xfer})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      init_q   <= 1'b0;
      outst_q  <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      AESState <= '0;
      AESKey   <= '0;
    end else begin
      init_q  <= 1'b1;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      // Tags never stall: the core has a fixed latency and credits bound occupancy
      tag_q   <= {tag_q[AESLatency-1:0], accept};
      if (accept) begin
        AESState <= CmdIn[127:0];
        AESKey   <= CmdIn[255:128];
      end
      if (fifo_wr) wptr_q <= wptr_q + PW'(1);
      if (xfer)    rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage is left unreset; only entries behind a valid count are ever observed
  always_ff @(posedge Clock) begin
    if (Reset && fifo_wr) begin
      assert (cnt_q != DEPTH);
      mem_q[wptr_q] <= AESOut;
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural aes_128 core model plus a transaction-level
// scoreboard (credits, arrival times, in-order ciphertexts) checked every cycle.
module tb_aes_stream_ctrl;
  localparam int L = 21;
  localparam int D = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [255:0] CmdIn = '0;
  logic         CmdInValid = 1'b0;
  logic         CmdInReady;
  logic [127:0] AESState, AESKey, AESOut, RspOut;
  logic         RspOutValid;
  logic         RspOutReady = 1'b0;

  always #5 Clock = ~Clock;

  aes_stream_ctrl #(.AESLatency(L), .FIFODepth(D)) dut (
    .Clock(Clock), .Reset(Reset), .CmdIn(CmdIn), .CmdInValid(CmdInValid),
    .CmdInReady(CmdInReady), .AESState(AESState), .AESKey(AESKey), .AESOut(AESOut),
    .RspOut(RspOut), .RspOutValid(RspOutValid), .RspOutReady(RspOutReady)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] xb, inv, r, s;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, x, a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        x = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[x];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] ^= w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // ---------------- aes_128 core model: samples inputs each edge, L-cycle latency ----------------
  logic [127:0] pipe [L];
  logic [127:0] last_k, last_s, last_ct;
  bit           have_last = 1'b0;
  always @(posedge Clock) begin
    if (!have_last || AESKey !== last_k || AESState !== last_s) begin
      last_k = AESKey; last_s = AESState;
      last_ct = aes128(AESKey, AESState);
      have_last = 1'b1;
    end
    pipe[0] <= last_ct;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign AESOut = pipe[L-1];

  // ---------------- scoreboard ----------------
  int           n_chk = 0, n_pass = 0;
  int           edge_n = 0;
  int           outst = 0, avail = 0;
  int           arr_q[$];
  logic [127:0] exp_q[$];
  bit           init_m = 1'b0;
  bit           last_acc, last_xf;
  int           acc_edge = 0;
  int           n_acc = 0, n_dut_acc = 0, n_dut_xf = 0;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit acc, xf, rdy_m, vld_m;
    #1;
    while (arr_q.size() > 0 && arr_q[0] <= edge_n) begin
      void'(arr_q.pop_front());
      avail++;
    end
    rdy_m = init_m && Reset && (outst < D);
    vld_m = Reset && (avail > 0);
    n_chk++;
    if (CmdInReady !== rdy_m) $display("FAIL cmd_ready @edge %0d: got %b want %b", edge_n, CmdInReady, rdy_m);
    else n_pass++;
    n_chk++;
    if (RspOutValid !== vld_m) $display("FAIL rsp_valid @edge %0d: got %b want %b", edge_n, RspOutValid, vld_m);
    else n_pass++;
    if (vld_m && exp_q.size() > 0) begin
      n_chk++;
      if (RspOut !== exp_q[0]) $display("FAIL rsp_data @edge %0d: got %h want %h", edge_n, RspOut, exp_q[0]);
      else n_pass++;
    end
    if (Reset && CmdInValid && CmdInReady === 1'b1) n_dut_acc++;
    if (Reset && RspOutReady && RspOutValid === 1'b1) n_dut_xf++;
    acc = rdy_m && CmdInValid;
    xf  = vld_m && RspOutReady;
    if (acc) begin
      exp_q.push_back(aes128(CmdIn[255:128], CmdIn[127:0]));
      arr_q.push_back(edge_n + L + 2);
      outst++; n_acc++;
      acc_edge = edge_n + 1;
    end
    if (xf) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      avail--; outst--;
    end
    last_acc = acc; last_xf = xf;
    @(posedge Clock);
    edge_n++;
    if (!Reset) begin
      exp_q.delete(); arr_q.delete();
      avail = 0; outst = 0; init_m = 1'b0;
    end else init_m = 1'b1;
    @(negedge Clock);
  endtask

  task automatic drain();
    CmdInValid = 1'b0; RspOutReady = 1'b1;
    for (int i = 0; i < L + 3*D + 8; i++) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_chk++;
    if (CmdInReady !== 1'b0 || RspOutValid !== 1'b0)
      $display("FAIL reset_outputs: got ready=%b valid=%b want 0/0", CmdInReady, RspOutValid);
    else n_pass++;
    Reset = 1'b1;
    step();
    n_chk++;
    if (CmdInReady !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", CmdInReady);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [127:0] got;
    int first, hi;
    first = -1; hi = 0; got = '0;
    CmdIn = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
    CmdInValid = 1'b1; RspOutReady = 1'b1;
    step();
    CmdInValid = 1'b0;
    for (int i = 0; i < L + 10; i++) begin
      if (RspOutValid === 1'b1) begin
        hi++;
        if (first < 0) begin first = edge_n; got = RspOut; end
      end
      step();
    end
    n_chk++;
    if (first - acc_edge != L + 1) $display("FAIL single_latency: got %0d want %0d", first - acc_edge, L + 1);
    else n_pass++;
    n_chk++;
    if (got !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
      $display("FAIL single_fips: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", got);
    else n_pass++;
    n_chk++;
    if (hi != 1) $display("FAIL single_valid_cycles: got %0d want 1", hi);
    else n_pass++;
  endtask

  task automatic test_burst();
    int got, cnt;
    got = 0; cnt = 0;
    RspOutReady = 1'b0; CmdInValid = 1'b1; CmdIn = rnd256();
    for (int i = 0; i < 40 && got < 4; i++) begin
      step();
      if (last_acc) begin got++; CmdIn = rnd256(); end
    end
    n_chk++;
    if (got != 4) $display("FAIL burst_accepts: got %0d want 4", got);
    else n_pass++;
    n_chk++;
    if (CmdInReady !== 1'b0) $display("FAIL burst_full_ready: got %b want 0", CmdInReady);
    else n_pass++;
    for (int i = 0; i < L + 3; i++) step();
    CmdInValid = 1'b0;
    n_chk++;
    if (RspOutValid !== 1'b1) $display("FAIL burst_buffered: got %b want 1", RspOutValid);
    else n_pass++;
    RspOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (RspOutValid === 1'b1) cnt++;
      step();
    end
    n_chk++;
    if (cnt != 4 || RspOutValid !== 1'b0)
      $display("FAIL burst_drain: got %0d words valid_after=%b want 4 words valid_after=0", cnt, RspOutValid);
    else n_pass++;
  endtask

  task automatic test_stream();
    int a0, d0, x0;
    a0 = n_acc; d0 = n_dut_acc; x0 = n_dut_xf;
    CmdInValid = 1'b1; RspOutReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      CmdIn = rnd256();
      step();
    end
    drain();
    n_chk++;
    if (n_dut_acc - d0 != n_acc - a0 || n_acc == a0)
      $display("FAIL stream_accepts: got %0d want %0d", n_dut_acc - d0, n_acc - a0);
    else n_pass++;
    n_chk++;
    if (n_dut_xf - x0 != n_acc - a0) $display("FAIL stream_responses: got %0d want %0d", n_dut_xf - x0, n_acc - a0);
    else n_pass++;
  endtask

  task automatic test_simul();
    int got;
    got = 0;
    RspOutReady = 1'b0; CmdInValid = 1'b1; CmdIn = rnd256();
    for (int i = 0; i < 20 && got < D - 1; i++) begin
      step();
      if (last_acc) begin got++; CmdIn = rnd256(); end
    end
    CmdInValid = 1'b0;
    for (int i = 0; i < L + 4; i++) step();
    CmdInValid = 1'b1; RspOutReady = 1'b1;
    n_chk++;
    if (CmdInReady !== 1'b1 || RspOutValid !== 1'b1)
      $display("FAIL simul_setup: got ready=%b valid=%b want 1/1", CmdInReady, RspOutValid);
    else n_pass++;
    step();
    CmdInValid = 1'b0; RspOutReady = 1'b0;
    n_chk++;
    if (CmdInReady !== 1'b1) $display("FAIL simul_ready_kept: got %b want 1", CmdInReady);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int got, hi;
    got = 0; hi = 0;
    RspOutReady = 1'b1; CmdInValid = 1'b1; CmdIn = rnd256();
    for (int i = 0; i < 20 && got < 3; i++) begin
      step();
      if (last_acc) begin got++; CmdIn = rnd256(); end
    end
    CmdInValid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    Reset = 1'b0;
    step(); step();
    Reset = 1'b1;
    for (int i = 0; i < L + 10; i++) begin
      if (RspOutValid !== 1'b0) hi++;
      step();
    end
    n_chk++;
    if (hi != 0) $display("FAIL reset_mid_stale: got %0d valid cycles want 0", hi);
    else n_pass++;
    CmdIn = rnd256(); CmdInValid = 1'b1;
    step();
    drain();
  endtask

  task automatic test_random();
    int got, x0, a0;
    got = 0; x0 = n_dut_xf; a0 = n_acc;
    for (int i = 0; i < 40000 && got < 1000; i++) begin
      CmdInValid  = ($urandom_range(0, 3) != 0);
      RspOutReady = ($urandom_range(0, 2) != 0);
      CmdIn = rnd256();
      step();
      if (last_acc) got++;
    end
    drain();
    n_chk++;
    if (got != 1000) $display("FAIL random_count: got %0d want 1000", got);
    else n_pass++;
    n_chk++;
    if (n_dut_xf - x0 != n_acc - a0) $display("FAIL random_responses: got %0d want %0d", n_dut_xf - x0, n_acc - a0);
    else n_pass++;
  endtask

  initial begin
    build_sbox();
    @(negedge Clock);
    test_reset();
    test_single();
    test_burst();
    test_stream();
    test_simul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter AESLatency, default 21: fixed cycles from aes_128 input sampling to its output.
REQ-002 Parameter FIFODepth, default 4: response FIFO entries (power of 2, >=2).
REQ-003 Clock  input  1  single clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 CmdIn  input  256  request word {Key[255:128], Data[127:0]}.
REQ-006 CmdInValid  input  1  CmdIn valid.
REQ-007 CmdInReady  output  1  block can accept CmdIn.
REQ-008 AESState  output  128  plaintext to aes_128 state port.
REQ-009 AESKey  output  128  key to aes_128 key port.
REQ-010 AESOut  input  128  ciphertext from aes_128 out port.
REQ-011 RspOut  output  128  ciphertext response, FIFO head.
REQ-012 RspOutValid  output  1  RspOut valid.
REQ-013 RspOutReady  input  1  consumer accepts RspOut.

Function
REQ-014 Accept occurs on an edge where CmdInValid && CmdInReady; transfer on RspOut occurs on an edge where RspOutValid && RspOutReady.
REQ-015 On accept, AESState <= CmdIn[127:0] and AESKey <= CmdIn[255:128]; both hold until the next accept.
REQ-016 Tag shift register, AESLatency+1 bits: bit0 <= accept each edge, bits shift one stage per edge, never stall.
REQ-017 When the final tag bit is 1, AESOut is written into the FIFO on that edge; untagged AESOut values are ignored.
REQ-018 Latency: accept on edge k -> FIFO write on edge k+AESLatency+1 -> RspOutValid high in the cycle after that edge (empty FIFO, no backpressure).
REQ-019 Credit counter Outstanding, width clog2(FIFODepth+1): +1 on accept, -1 on RspOut transfer, unchanged when both occur on the same edge.
REQ-020 CmdInReady = (Outstanding < FIFODepth) and not in reset; combinational from registered state, never from CmdInValid.
REQ-021 Accept back-to-back one per cycle while credits remain; Outstanding == FIFODepth -> CmdInReady low until a transfer.
REQ-022 Credits guarantee no FIFO overflow; a FIFO write while full is a design error (simulation assertion).
REQ-023 FIFO: first-word-fall-through, RspOut = head entry, RspOutValid = not empty; write and read on the same edge both take effect (count unchanged); read pointer and write pointer wrap modulo FIFODepth.
REQ-024 Responses leave in accept order; no reordering, no drop, no duplication.
REQ-025 RspOut and RspOutValid stay stable while RspOutValid && !RspOutReady.
REQ-026 CmdInValid while CmdInReady low: no state change; CmdIn ignored.

Reset
REQ-027 Reset low at an edge: Outstanding=0, tag register=0, FIFO pointers/count=0, AESState=0, AESKey=0.
REQ-028 During and in the cycle after reset: CmdInReady=0, RspOutValid=0; CmdInReady rises the first cycle after an edge with Reset high.
REQ-029 Reset mid-operation discards all in-flight and buffered results; late AESOut values are not written (tags cleared).

Verification
REQ-030 Single request: CmdIn={000102030405060708090a0b0c0d0e0f, 00112233445566778899aabbccddeeff}, RspOutReady=1 -> RspOut=69c4e0d86a7b0430d8cdb78070b4c55a, RspOutValid high exactly one cycle, AESLatency+1 edges after accept.
REQ-031 Burst of 4 distinct requests, RspOutReady=0 -> CmdInReady low after 4th accept; 4 responses buffered; raising RspOutReady drains them in order, one per cycle.
REQ-032 Steady streaming, RspOutReady=1, CmdInValid=1 for 100 cycles -> no accept lost, responses in order, Outstanding never exceeds FIFODepth.
REQ-033 Simultaneous accept and transfer with Outstanding=FIFODepth-1 -> Outstanding unchanged, CmdInReady stays high.
REQ-034 Reset asserted 10 cycles after accepting 3 requests -> no RspOutValid at any later cycle until a new accept; new request returns its correct ciphertext.
REQ-035 Random CmdInValid/RspOutReady toggling, 1000 requests against reference AES model -> all outputs match, ordering preserved, no overflow assertion.
